// File: rtl/vdc_video_out.sv
// rtl/vdc_video_out.sv - VDC to VCE pixel transmitter: sync generation and colour-index stream.
// Horizontal/vertical FSMs track hcount/vcount; registered outputs reflect the state at each ck_en.
module vdc_video_out #(
  parameter int          H_SW   = 8,
  parameter int          H_BP   = 24,
  parameter int          H_ACT  = 256,
  parameter int          H_FP   = 53,
  parameter int          V_SW   = 3,
  parameter int          V_BP   = 14,
  parameter int          V_ACT  = 240,
  parameter int          V_FP   = 5,
  parameter logic [8:0]  BORDER = 9'h100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ck_en,
  input  logic       pix_valid,
  input  logic [8:0] pix_data,
  output logic       pix_ready,
  output logic [8:0] VD,
  output logic       HSYN,
  output logic       VSYN,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       line_start,
  output logic       frame_start,
  output logic       underrun,
  input  logic       underrun_clr
);

  typedef enum logic [1:0] {HSW, HDS, HDW, HDE} h_state_t;
  typedef enum logic [1:0] {VSW, VDS, VDW, VDE} v_state_t;

  // Last position of each phase, in pixels / lines from the start of the line / frame.
  localparam logic [8:0] H_END_SW  = 9'(H_SW - 1);
  localparam logic [8:0] H_END_BP  = 9'(H_SW + H_BP - 1);
  localparam logic [8:0] H_END_ACT = 9'(H_SW + H_BP + H_ACT - 1);
  localparam logic [8:0] H_LAST    = 9'(H_SW + H_BP + H_ACT + H_FP - 1);
  localparam logic [8:0] V_END_SW  = 9'(V_SW - 1);
  localparam logic [8:0] V_END_BP  = 9'(V_SW + V_BP - 1);
  localparam logic [8:0] V_END_ACT = 9'(V_SW + V_BP + V_ACT - 1);
  localparam logic [8:0] V_LAST    = 9'(V_SW + V_BP + V_ACT + V_FP - 1);

  h_state_t h_state, h_next;
  v_state_t v_state, v_next;
  logic     h_wrap;
  logic     v_wrap;
  logic     active;

  always_comb begin
    h_next = h_state;
    h_wrap = 1'b0;
    case (h_state)
      HSW: if (hcount == H_END_SW)  h_next = HDS;
      HDS: if (hcount == H_END_BP)  h_next = HDW;
      HDW: if (hcount == H_END_ACT) h_next = HDE;
      HDE: if (hcount == H_LAST) begin
        h_next = HSW;
        h_wrap = 1'b1;
      end
      default: h_next = HSW;
    endcase
  end

  // Vertical FSM only moves on the last pixel of a line.
  always_comb begin
    v_next = v_state;
    v_wrap = 1'b0;
    if (h_wrap) begin
      case (v_state)
        VSW: if (vcount == V_END_SW)  v_next = VDS;
        VDS: if (vcount == V_END_BP)  v_next = VDW;
        VDW: if (vcount == V_END_ACT) v_next = VDE;
        VDE: if (vcount == V_LAST) begin
          v_next = VSW;
          v_wrap = 1'b1;
        end
        default: v_next = VSW;
      endcase
    end
  end

  assign active    = (h_state == HDW) && (v_state == VDW);
  assign pix_ready = ck_en & active & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_state     <= HSW;
      v_state     <= VSW;
      hcount      <= 9'd0;
      vcount      <= 9'd0;
      VD          <= BORDER;
      HSYN        <= 1'b1;
      VSYN        <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ck_en) begin
      h_state     <= h_next;
      v_state     <= v_next;
      hcount      <= h_wrap ? 9'd0 : hcount + 9'd1;
      if (h_wrap) vcount <= v_wrap ? 9'd0 : vcount + 9'd1;
      HSYN        <= ~(h_state == HSW);
      VSYN        <= ~(v_state == VSW);
      VD          <= (active && pix_valid) ? pix_data : BORDER;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  // A fresh underrun takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (ck_en && active && !pix_valid) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vdc_video_out.sv
// tb/tb_vdc_video_out.sv - randomized self-checking bench for vdc_video_out.
// A pixel/line position model predicts sync, VD, pulses and underrun from the timing rules.
module tb_vdc_video_out;

  localparam int H_SW = 4, H_BP = 5, H_ACT = 16, H_FP = 6;
  localparam int V_SW = 2, V_BP = 3, V_ACT = 6, V_FP = 2;
  localparam int H_TOT = H_SW + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SW + V_BP + V_ACT + V_FP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int H_A0  = H_SW + H_BP;
  localparam int V_A0  = V_SW + V_BP;
  localparam logic [8:0] BORDER = 9'h100;

  logic       clk = 1'b0;
  logic       reset;
  logic       ck_en;
  logic       pix_valid;
  logic [8:0] pix_data;
  logic       pix_ready;
  logic [8:0] VD;
  logic       HSYN;
  logic       VSYN;
  logic [8:0] hcount;
  logic [8:0] vcount;
  logic       line_start;
  logic       frame_start;
  logic       underrun;
  logic       underrun_clr;

  always #5 clk = ~clk;

  vdc_video_out #(
    .H_SW(H_SW), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SW(V_SW), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
    .BORDER(BORDER)
  ) dut (
    .clk(clk), .reset(reset), .ck_en(ck_en),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .VD(VD), .HSYN(HSYN), .VSYN(VSYN), .hcount(hcount), .vcount(vcount),
    .line_start(line_start), .frame_start(frame_start),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  int tests = 0;
  int fails = 0;

  int         m_h, m_v;
  logic [8:0] e_vd;
  bit         e_hs, e_vs, e_ls, e_fs, e_ur;
  int         xfers, frame_xfers;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", tag, got, exp, m_h, m_v, $time);
    end
  endtask

  function automatic bit in_act(input int h, input int v);
    return (h >= H_A0) && (h < H_A0 + H_ACT) && (v >= V_A0) && (v < V_A0 + V_ACT);
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0;
    e_vd = BORDER; e_hs = 1'b1; e_vs = 1'b1;
    e_ls = 1'b0; e_fs = 1'b0; e_ur = 1'b0;
    xfers = 0;
  endtask

  task automatic check_outputs();
    chk("VD", 32'(VD), 32'(e_vd));
    chk("HSYN", 32'(HSYN), 32'(e_hs));
    chk("VSYN", 32'(VSYN), 32'(e_vs));
    chk("line_start", 32'(line_start), 32'(e_ls));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("underrun", 32'(underrun), 32'(e_ur));
    chk("hcount", 32'(hcount), 32'(m_h));
    chk("vcount", 32'(vcount), 32'(m_v));
  endtask

  // One clk: check last edge's results, drive inputs, check pix_ready, advance the model.
  task automatic cycle(input bit ck, input bit v, input logic [8:0] d, input bit clr);
    bit act;
    bit wrap;
    @(negedge clk);
    check_outputs();
    ck_en = ck; pix_valid = v; pix_data = d; underrun_clr = clr;
    #1;
    act = in_act(m_h, m_v);
    chk("pix_ready", 32'(pix_ready), 32'(ck && act));
    if (ck) begin
      e_hs = !(m_h < H_SW);
      e_vs = !(m_v < V_SW);
      e_vd = (act && v) ? d : BORDER;
      if (act && v) xfers++;
      wrap = (m_h == H_TOT - 1);
      e_ls = wrap;
      e_fs = wrap && (m_v == V_TOT - 1);
      if (e_fs) begin
        frame_xfers = xfers;
        xfers = 0;
      end
      m_h = wrap ? 0 : m_h + 1;
      if (wrap) m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
    end else begin
      e_ls = 1'b0;
      e_fs = 1'b0;
    end
    if (ck && act && !v) e_ur = 1'b1;
    else if (clr) e_ur = 1'b0;
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(m_h == h && m_v == v) && n < 2 * FRAME) begin
      cycle(1'b1, 1'b1, 9'($urandom), 1'b0);
      n++;
    end
    if (n >= 2 * FRAME) chk("run_to_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ck_en = 1'b1; pix_valid = 1'b1; underrun_clr = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("pix_ready_in_reset", 32'(pix_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0; ck_en = 1'b0; pix_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ck_en = 1'b0; pix_valid = 1'b0; pix_data = '0; underrun_clr = 1'b0;
    model_reset();
    frame_xfers = 0;
    repeat (3) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Free-running pixel clock, no upstream data: sync shapes and pulse spacing.
    for (int i = 0; i < 2 * FRAME; i++) cycle(1'b1, 1'b0, 9'd0, 1'b0);
    cycle(1'b0, 1'b0, 9'd0, 1'b1);

    // Quarter-rate pixel clock with a ramp; one full frame of transfers.
    xfers = 0;
    for (int i = 0; i < 4 * FRAME; i++)
      cycle((i % 4) == 0, 1'b1, 9'(m_h - H_A0), 1'b0);
    chk("frame_xfers", 32'(frame_xfers), 32'(H_ACT * V_ACT));
    chk("underrun_clean", 32'(underrun), 32'd0);

    // Single dropped pixel mid-line, then normal transfer.
    run_to(H_A0 + 3, V_A0 + 1);
    cycle(1'b1, 1'b0, 9'h0AA, 1'b0);
    cycle(1'b1, 1'b1, 9'h055, 1'b0);
    cycle(1'b0, 1'b0, 9'h000, 1'b0);

    // Clear collides with a fresh underrun, then clear alone.
    cycle(1'b0, 1'b0, 9'h000, 1'b1);
    run_to(H_A0 + 6, V_A0 + 1);
    cycle(1'b1, 1'b0, 9'h000, 1'b1);
    cycle(1'b0, 1'b0, 9'h000, 1'b1);
    cycle(1'b0, 1'b0, 9'h000, 1'b0);

    // Valid held with no pixel clock inside the active window.
    run_to(H_A0 + 8, V_A0 + 2);
    repeat (10) cycle(1'b0, 1'b1, 9'($urandom), 1'b0);
    cycle(1'b1, 1'b1, 9'h1C3, 1'b0);

    // Randomized pixel-clock, valid and clear activity.
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 9) != 0,
            9'($urandom), $urandom_range(0, 15) == 0);

    // Reset in the middle of an active line.
    run_to(H_A0 + 10, V_A0 + 3);
    do_reset();
    for (int i = 0; i < 3 * H_TOT; i++)
      cycle($urandom_range(0, 1) != 0, 1'b1, 9'($urandom), 1'b0);

    @(negedge clk);
    check_outputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vdc_video_out.md
Name: vdc_video_out

Overview:
- Transmit end of the VDC→VCE pixel interface: generates HSYN/VSYN and the 9-bit colour-index stream VD that the VCE resolves through CRAM into RGB.
- Advances one pixel per VCE pixel-clock enable (ck_en, derived from the VCE's CK divider).
- Consumes indices from the upstream VDC background/sprite mixer over a valid/ready stream.
- Substitutes the border index during blanking and on underrun.

Parameters:
- H_SW, 8, horizontal sync width in pixels
- H_BP, 24, horizontal back porch in pixels
- H_ACT, 256, active pixels per line
- H_FP, 53, horizontal front porch in pixels (total 341)
- V_SW, 3, vertical sync width in lines
- V_BP, 14, vertical back porch in lines
- V_ACT, 240, active lines per frame
- V_FP, 5, vertical front porch in lines (total 262)
- BORDER, 9'h100, index driven outside the active window and on underrun

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- ck_en  input  1  pixel-clock enable, one clk wide; all timing advances only on ck_en
- pix_valid  input  1  upstream pixel index available
- pix_data  input  9  upstream colour index
- pix_ready  output  1  combinational; = ck_en & active & ~reset
- VD  output  9  registered colour index to the VCE
- HSYN  output  1  registered horizontal sync, active-low
- VSYN  output  1  registered vertical sync, active-low
- hcount  output  9  current pixel position in line, 0..H_total-1
- vcount  output  9  current line, 0..V_total-1
- line_start  output  1  one-clk pulse when hcount wraps to 0
- frame_start  output  1  one-clk pulse when hcount and vcount both wrap to 0
- underrun  output  1  sticky flag: an active pixel had no valid input
- underrun_clr  input  1  clears underrun

Behaviour:
- Reset values:
  - hcount = 0, vcount = 0, H state = HSW, V state = VSW.
  - VD = BORDER, HSYN = 1, VSYN = 1.
  - line_start = 0, frame_start = 0, underrun = 0.
- Reset mid-frame aborts immediately. The first ck_en after deassertion is treated as pixel 0 of line 0, so HSYN and VSYN go low together.
- Horizontal FSM, advanced on ck_en; hcount increments each ck_en:
  - HSW lasts H_SW pixels, then HDS.
  - HDS lasts H_BP pixels, then HDW.
  - HDW lasts H_ACT pixels, then HDE.
  - HDE lasts H_FP pixels, then HSW. On this transition hcount wraps to 0, line_start pulses and vcount advances.
- Vertical FSM, advanced only when the horizontal FSM wraps: VSW (V_SW lines) → VDS (V_BP) → VDW (V_ACT) → VDE (V_FP) → VSW. On the wrap to VSW, vcount resets to 0 and frame_start pulses together with line_start.
- active = (H state == HDW) & (V state == VDW). The registered outputs lag the state by one ck_en: they reflect the state in effect at that ck_en.
- On each ck_en:
  - HSYN <= ~(H state == HSW).
  - VSYN <= ~(V state == VSW).
  - VD:
    - If active and pix_valid: VD <= pix_data (transfer).
    - If active and !pix_valid: VD <= BORDER and underrun <= 1.
    - Otherwise: VD <= BORDER.
- Without ck_en, all registers hold. pix_ready is 0, so no transfer occurs even if pix_valid = 1.
- Handshake: a transfer happens only on a cycle with pix_valid & pix_ready. Upstream must hold pix_data stable while valid is high and not accepted. Exactly H_ACT × V_ACT transfers occur per frame when no underrun happens.
- Latency: pix_data accepted at ck_en edge n appears on VD after that same clk edge (1 clk).
- Underrun flag:
  - Sticky until underrun_clr.
  - If underrun_clr and a new underrun occur in the same clock, set wins.
- Counter widths: 9 bits; H total = 341 and V total = 262 both fit. A parameter set with a total above 511 is unsupported.
- ck_en held high every clk is legal; maximum rate is one pixel per clk.

Test Plan:
- Reset, then ck_en every clk and pix_valid = 0 → HSYN low for pixels 0–7, high from 8; line_start every 341 clk; VSYN low for lines 0–2; frame_start every 89,342 clk.
- ck_en every 4th clk, pix_valid = 1, pix_data = hcount-32 → pix_ready high only at pixels 32–287 of lines 17–256; VD shows 0..255 per active line; 61,440 transfers per frame; underrun stays 0.
- Same as the previous scenario but pix_valid dropped at pixel 100 of line 20 → VD = 9'h100 at that pixel, underrun = 1 and stays 1; the following pixel with valid is transferred normally.
- underrun_clr pulsed in the same clk as a fresh underrun → underrun stays 1; clr alone on the next clk → 0.
- pix_valid held high with ck_en = 0 for 10 clk during the active region → no transfer; VD, hcount and the counters unchanged.
- Assert reset at line 100, pixel 150 → all outputs at reset values immediately; after release, the first ck_en gives HSYN = VSYN = 0 and hcount = vcount = 0.
